phase_inc_sweep: RTL and testbench

Programmable frequency-sweep (stepped chirp) generator sitting directly upstream of the CORDIC/DAC tone generator. It drives that stage's `phase_inc` input, stepping from a start increment to a stop increment in fixed steps. Each level is held for a programmable dwell time. It is configured and triggered by CPU CSRs and reports busy/done status back to them.

---
 rtl/phase_inc_sweep_if.sv | 27 ++
 rtl/phase_inc_sweep.sv | 146 ++++++++++++++
 tb/tb_phase_inc_sweep.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/phase_inc_sweep_if.sv
// Config/trigger and status bundle between the CSR block and the phase-increment sweep generator.
interface phase_inc_sweep_if #(
    parameter int PW = 19,
    parameter int DW = 16
);
    logic [PW-1:0] start_inc;
    logic [PW-1:0] stop_inc;
    logic [PW-1:0] step_inc;
    logic [DW-1:0] dwell;
    logic          loop;
    logic          start;
    logic          abort;
    logic [PW-1:0] phase_inc;
    logic          busy;
    logic          done;
    logic          step_stb;

    modport master (
        output start_inc, stop_inc, step_inc, dwell, loop, start, abort,
        input  phase_inc, busy, done, step_stb
    );

    modport slave (
        input  start_inc, stop_inc, step_inc, dwell, loop, start, abort,
        output phase_inc, busy, done, step_stb
    );
endinterface

// File: rtl/phase_inc_sweep.sv
// Stepped-chirp phase-increment generator feeding the CORDIC/DAC tone stage.
// Optional macro PHASE_INC_SWEEP_LOOP_EN enables seamless pass repetition via the loop input.
module phase_inc_sweep #(
    parameter int PW = 19,
    parameter int DW = 16
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    phase_inc_sweep_if.slave  bus
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] cnt, cnt_nxt;
    logic [PW-1:0] cur, cur_nxt;
    logic          busy_q, busy_nxt;
    logic          done_q, done_nxt;
    logic          stb_q, stb_nxt;
    logic          cfg_ld;

    logic [PW-1:0] stop_q;
    logic [PW-1:0] step_q;
    logic [DW-1:0] reload_q;
    logic          up_q;
`ifdef PHASE_INC_SWEEP_LOOP_EN
    logic [PW-1:0] first_q;
`else
    logic          loop_unused;
    assign loop_unused = bus.loop;
`endif

    function automatic logic [DW-1:0] dwell_m1(input logic [DW-1:0] d);
        return (d == '0) ? '0 : d - DW'(1);
    endfunction

    // Saturating step toward the stop level; a zero step jumps straight to it.
    function automatic logic [PW-1:0] step_up(input logic [PW-1:0] c,
                                              input logic [PW-1:0] s,
                                              input logic [PW-1:0] lim);
        logic [PW:0] sum;
        sum = {1'b0, c} + {1'b0, s};
        if ((s == '0) || (sum > {1'b0, lim}))
            return lim;
        return sum[PW-1:0];
    endfunction

    function automatic logic [PW-1:0] step_dn(input logic [PW-1:0] c,
                                              input logic [PW-1:0] s,
                                              input logic [PW-1:0] lim);
        logic [PW:0] diff;
        diff = {1'b0, c} - {1'b0, s};
        if ((s == '0) || diff[PW] || (diff[PW-1:0] < lim))
            return lim;
        return diff[PW-1:0];
    endfunction

    // Config snapshot: data only, so no reset.
    always_ff @(posedge sys_clk) begin
        if (cfg_ld) begin
            stop_q   <= bus.stop_inc;
            step_q   <= bus.step_inc;
            reload_q <= dwell_m1(bus.dwell);
            up_q     <= (bus.stop_inc >= bus.start_inc);
`ifdef PHASE_INC_SWEEP_LOOP_EN
            first_q  <= bus.start_inc;
`endif
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            cur    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            stb_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            cur    <= cur_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
            stb_q  <= stb_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cur_nxt   = cur;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        stb_nxt   = 1'b0;
        cfg_ld    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    cfg_ld    = 1'b1;
                    cur_nxt   = bus.start_inc;
                    cnt_nxt   = dwell_m1(bus.dwell);
                    stb_nxt   = 1'b1;
                    busy_nxt  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - DW'(1);
                end else if (cur == stop_q) begin
                    done_nxt = 1'b1;
`ifdef PHASE_INC_SWEEP_LOOP_EN
                    // loop is sampled live here so clearing it mid-pass ends after this pass.
                    if (bus.loop) begin
                        cur_nxt = first_q;
                        cnt_nxt = reload_q;
                        stb_nxt = 1'b1;
                    end else begin
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
`else
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
`endif
                end else begin
                    cur_nxt = up_q ? step_up(cur, step_q, stop_q)
                                   : step_dn(cur, step_q, stop_q);
                    cnt_nxt = reload_q;
                    stb_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.phase_inc = cur;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.step_stb  = stb_q;

endmodule

// File: tb/tb_phase_inc_sweep.sv
// Directed, table-driven bench for phase_inc_sweep (loop checks follow PHASE_INC_SWEEP_LOOP_EN).
module tb_phase_inc_sweep;

    localparam int PW = 19;
    localparam int DW = 16;

    typedef struct {
        logic [PW-1:0]      s;
        logic [PW-1:0]      e;
        logic [PW-1:0]      st;
        logic [DW-1:0]      dw;
        int                 n;
        int                 d;
        logic [3:0][PW-1:0] lv;
    } vec_t;

    logic sys_clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;
    vec_t vt [7];
    vec_t v_up;
    logic [PW-1:0] up_lv [4];

    phase_inc_sweep_if #(.PW(PW), .DW(DW)) bus ();

    phase_inc_sweep #(.PW(PW), .DW(DW)) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus.slave)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    function automatic vec_t mk(input logic [PW-1:0] s, input logic [PW-1:0] e,
                                input logic [PW-1:0] st, input logic [DW-1:0] dw,
                                input int n, input int d,
                                input logic [PW-1:0] l0, input logic [PW-1:0] l1,
                                input logic [PW-1:0] l2, input logic [PW-1:0] l3);
        vec_t r;
        r.s = s; r.e = e; r.st = st; r.dw = dw; r.n = n; r.d = d;
        r.lv[0] = l0; r.lv[1] = l1; r.lv[2] = l2; r.lv[3] = l3;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [PW-1:0] e_inc,
                       input logic e_busy, input logic e_done, input logic e_stb);
        chk({tag, " phase_inc"}, 32'(bus.phase_inc), 32'(e_inc));
        chk({tag, " busy"},      32'(bus.busy),      32'(e_busy));
        chk({tag, " done"},      32'(bus.done),      32'(e_done));
        chk({tag, " step_stb"},  32'(bus.step_stb),  32'(e_stb));
    endtask

    task automatic set_cfg(input vec_t v);
        bus.start_inc = v.s;
        bus.stop_inc  = v.e;
        bus.step_inc  = v.st;
        bus.dwell     = v.dw;
    endtask

    // Called at a negedge; ends at the negedge of the done cycle.
    task automatic run_sweep(input vec_t v, input int poke_at, input string tag);
        int nd;
        nd = v.n * v.d;
        set_cfg(v);
        bus.start = 1'b1;
        @(negedge sys_clk);
        bus.start = 1'b0;
        for (int k = 0; k <= nd; k++) begin
            if (k > 0) @(negedge sys_clk);
            if (k == nd)
                cyc($sformatf("%s k=%0d", tag, k), v.e, 1'b0, 1'b1, 1'b0);
            else
                cyc($sformatf("%s k=%0d", tag, k), v.lv[k / v.d], 1'b1, 1'b0, (k % v.d) == 0);
            if (k == poke_at) begin
                bus.start_inc = v.s + 19'd7;
                bus.stop_inc  = v.e + 19'd3;
                bus.step_inc  = 19'd1;
                bus.start     = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_miss = 0;
        rst_n = 1'b0;
        bus.start_inc = '0; bus.stop_inc = '0; bus.step_inc = '0; bus.dwell = '0;
        bus.loop = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
        up_lv[0] = 19'd100; up_lv[1] = 19'd110; up_lv[2] = 19'd120; up_lv[3] = 19'd130;

        v_up  = mk(19'd100, 19'd130, 19'd10, 16'd3, 4, 3, 19'd100, 19'd110, 19'd120, 19'd130);
        vt[0] = v_up;
        vt[1] = mk(19'd1000, 19'd975, 19'd10, 16'd0, 4, 1, 19'd1000, 19'd990, 19'd980, 19'd975);
        vt[2] = mk(19'h7FFF0, 19'h7FFFF, 19'h20, 16'd1, 2, 1, 19'h7FFF0, 19'h7FFFF, 19'd0, 19'd0);
        vt[3] = mk(19'd5, 19'd0, 19'd8, 16'd2, 2, 2, 19'd5, 19'd0, 19'd0, 19'd0);
        vt[4] = mk(19'd50, 19'd60, 19'd0, 16'd2, 2, 2, 19'd50, 19'd60, 19'd0, 19'd0);
        vt[5] = mk(19'd77, 19'd77, 19'd5, 16'd4, 1, 4, 19'd77, 19'd0, 19'd0, 19'd0);
        vt[6] = mk(19'd30, 19'd10, 19'd10, 16'd1, 3, 1, 19'd30, 19'd20, 19'd10, 19'd0);

        #12;
        cyc("reset", 19'd0, 1'b0, 1'b0, 1'b0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
        cyc("idle", 19'd0, 1'b0, 1'b0, 1'b0);

        // Back-to-back: each start is raised in the previous sweep's done cycle.
        for (int i = 0; i < 7; i++)
            run_sweep(vt[i], -1, $sformatf("vec%0d", i));
        @(negedge sys_clk);
        cyc("hold_stop", vt[6].e, 1'b0, 1'b0, 1'b0);

        // Abort while at level 110.
        set_cfg(v_up);
        bus.start = 1'b1;
        @(negedge sys_clk);
        bus.start = 1'b0;
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) @(negedge sys_clk);
            cyc($sformatf("abort_pre k=%0d", k), up_lv[k / 3], 1'b1, 1'b0, (k % 3) == 0);
        end
        bus.abort = 1'b1;
        @(negedge sys_clk);
        bus.abort = 1'b0;
        cyc("abort_hit", 19'd110, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge sys_clk);
            cyc($sformatf("abort_after k=%0d", k), 19'd110, 1'b0, 1'b0, 1'b0);
        end

        // start and abort together in IDLE: nothing starts.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge sys_clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        cyc("start_abort", 19'd110, 1'b0, 1'b0, 1'b0);
        @(negedge sys_clk);
        cyc("start_abort2", 19'd110, 1'b0, 1'b0, 1'b0);

        // start (with altered config) while busy is ignored.
        run_sweep(v_up, 1, "start_busy");

        // Asynchronous reset at level 120.
        set_cfg(v_up);
        bus.start = 1'b1;
        @(negedge sys_clk);
        bus.start = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) @(negedge sys_clk);
            cyc($sformatf("rst_pre k=%0d", k), up_lv[k / 3], 1'b1, 1'b0, (k % 3) == 0);
        end
        #2 rst_n = 1'b0;
        #1 cyc("rst_async", 19'd0, 1'b0, 1'b0, 1'b0);
        @(negedge sys_clk);
        cyc("rst_held", 19'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        run_sweep(v_up, -1, "post_rst");

        // Loop behaviour.
        set_cfg(v_up);
        bus.loop  = 1'b1;
        bus.start = 1'b1;
        @(negedge sys_clk);
        bus.start = 1'b0;
`ifdef PHASE_INC_SWEEP_LOOP_EN
        for (int k = 0; k <= 24; k++) begin
            if (k > 0) @(negedge sys_clk);
            if (k == 24)
                cyc("loop k=24", 19'd130, 1'b0, 1'b1, 1'b0);
            else
                cyc($sformatf("loop k=%0d", k), up_lv[(k % 12) / 3], 1'b1, k == 12, (k % 3) == 0);
            if (k == 18) bus.loop = 1'b0;
        end
`else
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) @(negedge sys_clk);
            if (k == 12)
                cyc("noloop k=12", 19'd130, 1'b0, 1'b1, 1'b0);
            else
                cyc($sformatf("noloop k=%0d", k), up_lv[k / 3], 1'b1, 1'b0, (k % 3) == 0);
        end
        bus.loop = 1'b0;
`endif
        @(negedge sys_clk);
        cyc("loop_end_hold", 19'd130, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
